// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-precision add/subtract sequencer.
// A single 4-bit carry-look-ahead adder is time-shared across WIDTH/4 nibbles,
// LSB nibble first. The carry between nibbles lives in a register.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. Each ready/valid is driven purely from FSM
// state. Input side: in_ready=1 only in IDLE. Output side: out_valid=1 only in
// DONE, where Sum/Cout/Ovf/Zero are held stable until out_ready is seen.

// 4-bit carry-look-ahead adder: all carries derive directly from P/G and Cin.
module cla_adder4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic [1:0]       o_dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bm;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_add_sum;
  logic             w_add_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_msb_carry;

  // Handshake outputs come from state alone; no path from in_valid/out_ready.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign w_accept    = in_ready & in_valid;
  assign w_last      = (r_cnt == LAST_NIB);
  assign o_dbg_state = r_state;

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;
  assign Zero = r_zero;

  // Select the operand nibbles for the current step with constant part-selects.
  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_bm[4*i +: 4];
      end
    end
  end

  cla_adder4bits u_cla (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Result as it will look after this step: current nibble replaced by adder sum.
  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < NIB; i++) begin
      if (r_cnt == CW'(i)) begin
        w_sum_next[4*i +: 4] = w_add_sum;
      end
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
  assign w_msb_carry = w_sum_next[WIDTH-1] ^ r_a[WIDTH-1] ^ r_bm[WIDTH-1];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_state_next = S_RUN;
      S_RUN:  if (w_last)    w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one nibble per clock in RUN.
  // Subtraction is A + ~B + ~borrow, so Bm and the carry seed absorb Sub and
  // nothing downstream needs to know which operation is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_bm    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_bm    <= Sub ? ~B : B;
      r_carry <= Cin ^ Sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_add_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_add_cout;
        r_ovf  <= w_msb_carry ^ w_add_cout;
        r_zero <= (w_sum_next == '0);
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed table of add/subtract vectors, hand-written
// back-pressure and reset sequences, and a randomised run against a model.
module tb_cla_seq_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         Zero;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected results as {cout, ovf, zero, sum}.
  logic [W+2:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[13];

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .Sub         (Sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Sum         (Sum),
    .Cout        (Cout),
    .Ovf         (Ovf),
    .Zero        (Zero),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: subtraction as A + ~B + ~borrow, signed overflow from operand signs.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0] r;
    logic       ovf;
    if (sub) begin
      r   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin};
      ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {r[W], ovf, (r[W-1:0] == '0), r[W-1:0]};
  endfunction

  // Scoreboard: compare a collected result with the head of the expected queue.
  task automatic sb_check(input logic [W+2:0] got);
    logic [W+2:0] exp;
    if (exp_q.size() == 0) begin
      check("sb_queue_nonempty", 32'd0, 32'd1);
      return;
    end
    exp = exp_q.pop_front();
    check("sum",  32'(got[W-1:0]), 32'(exp[W-1:0]));
    check("cout", 32'(got[W+2]),   32'(exp[W+2]));
    check("ovf",  32'(got[W+1]),   32'(exp[W+1]));
    check("zero", 32'(got[W]),     32'(exp[W]));
  endtask

  // Driver: one full transaction starting at a negedge in IDLE.
  // stall = cycles of out_ready=0 after out_valid (with junk in_valid pulses);
  // early = out_ready held high from the accept onwards.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W+2:0] exp, input int stall,
                        input bit early);
    logic [W+2:0] got;
    int           n;
    bit           ready_in_run;
    exp_q.push_back(exp);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    if (early) out_ready = 1'b1;
    n = 0;
    ready_in_run = 1'b0;
    while (!out_valid && n < 12) begin
      if (in_ready) ready_in_run = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("in_ready_low_in_run", 32'(ready_in_run), 32'd0);
    got = {Cout, Ovf, Zero, Sum};
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        A = 16'($urandom); B = 16'($urandom);
        @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_outputs", 32'({Cout, Ovf, Zero, Sum}), 32'(got));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    sb_check(got);
  endtask

  initial begin
    int seen_valid;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    int           st;
    bit           er;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

    //           a         b         cin   sub   sum       cout  ovf   zero
    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].sum},
             i % 3, (i == 3));
    end

    // Back-pressure for 5 cycles, then a back-to-back accept on release
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h5555}, 5, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, 0, 1'b0);

    // Reset while k=2 in RUN aborts the operation
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(Sum), 32'd0);
    check("abort_flags", 32'({Cout, Ovf, Zero}), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);

    // Reset together with in_valid in IDLE: no accept
    A = 16'h0005; B = 16'h0005; rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_accept_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen_valid++;
    end
    check("rst_accept_no_op", 32'(seen_valid), 32'd0);
    run_op(16'h0010, 16'h0000, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 16'h000F}, 1, 1'b0);

    // Randomised regression against the model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      st = $urandom_range(0, 3);
      er = (st == 0) && ($urandom_range(0, 1) == 1);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), st, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
